// File: rtl/dp_ram_pkg.sv
// Shared constants and helpers for the dp_ram_pipe dual-port RAM.
package dp_ram_pkg;

    // Read-during-write selection
    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    // Legal read latency range
    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 2;

    // Even parity over a word of up to 64 bits (zero-extend narrower words)
    function automatic logic calc_parity(input logic [63:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/dp_ram_rd_pipe.sv
// Read-response pipeline for one RAM port: RD_LATENCY register stages,
// holds the last valid word when idle, flushed by reset.
// Parity error output exists only when DP_RAM_PARITY_EN is defined.
module dp_ram_rd_pipe
    import dp_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_stb,
    input  logic [DATA_WIDTH-1:0] rd_data,
`ifdef DP_RAM_PARITY_EN
    input  logic                  rd_perr,
    output logic                  perr,
`endif
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_vld
);

    logic                  pre_vld;
    logic [DATA_WIDTH-1:0] pre_dat;
`ifdef DP_RAM_PARITY_EN
    logic                  pre_perr;
`endif

    if (RD_LATENCY == LAT_MAX) begin : g_lat2
        logic                  s_vld;
        logic [DATA_WIDTH-1:0] s_dat;
`ifdef DP_RAM_PARITY_EN
        logic                  s_perr;
`endif
        // Extra stage for two-cycle latency; reset drops an in-flight read
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s_vld  <= 1'b0;
                s_dat  <= '0;
`ifdef DP_RAM_PARITY_EN
                s_perr <= 1'b0;
`endif
            end else begin
                s_vld  <= rd_stb;
                s_dat  <= rd_data;
`ifdef DP_RAM_PARITY_EN
                s_perr <= rd_perr;
`endif
            end
        end
        assign pre_vld  = s_vld;
        assign pre_dat  = s_dat;
`ifdef DP_RAM_PARITY_EN
        assign pre_perr = s_perr;
`endif
    end else begin : g_lat1
        assign pre_vld  = rd_stb;
        assign pre_dat  = rd_data;
`ifdef DP_RAM_PARITY_EN
        assign pre_perr = rd_perr;
`endif
    end

    // Output stage: data only loads on a valid read, so it holds otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_vld  <= 1'b0;
`ifdef DP_RAM_PARITY_EN
            perr     <= 1'b0;
`endif
        end else begin
            out_vld <= pre_vld;
            if (pre_vld) out_data <= pre_dat;
`ifdef DP_RAM_PARITY_EN
            perr    <= pre_vld & pre_perr;
`endif
        end
    end

endmodule

// File: rtl/dp_ram_pipe.sv
// True dual-port synchronous RAM with pipelined reads, cross-port
// read-during-write selection, write/write collision arbitration (port 1
// wins) and out-of-range protection. Optional parity: DP_RAM_PARITY_EN.
module dp_ram_pipe
    import dp_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16,
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_1,
    input  logic                  wr_1,
    input  logic [ADDR_WIDTH-1:0] add_1,
    input  logic [DATA_WIDTH-1:0] data_1,
    output logic [DATA_WIDTH-1:0] out_1,
    output logic                  vld_1,
    input  logic                  en_2,
    input  logic                  wr_2,
    input  logic [ADDR_WIDTH-1:0] add_2,
    input  logic [DATA_WIDTH-1:0] data_2,
    output logic [DATA_WIDTH-1:0] out_2,
    output logic                  vld_2,
`ifdef DP_RAM_PARITY_EN
    input  logic                  inj_par_1,
    output logic                  perr_1,
    output logic                  perr_2,
`endif
    output logic                  coll,
    output logic                  oor
);

    if (RD_LATENCY < LAT_MIN || RD_LATENCY > LAT_MAX || DEPTH < 1 ||
        DEPTH > 2**ADDR_WIDTH) begin : g_param_err
        $error("dp_ram_pipe: illegal RD_LATENCY or DEPTH");
    end

    localparam int                  IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
    localparam bit                  FWD     = (RDW_MODE != RDW_OLD) && (RDW_MODE == RDW_NEW);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic             oor_a1, oor_a2, same_a;
    logic             wr_ok_1, wr_ok_2, rd_1, rd_2, fwd_1, fwd_2;
    logic [IDX_W-1:0] idx_1, idx_2;
    logic [DATA_WIDTH-1:0] rdata_1, rdata_2;

    assign oor_a1  = {1'b0, add_1} >= DEPTH_W;
    assign oor_a2  = {1'b0, add_2} >= DEPTH_W;
    assign same_a  = (add_1 == add_2);
    assign idx_1   = add_1[IDX_W-1:0];
    assign idx_2   = add_2[IDX_W-1:0];
    assign rd_1    = en_1 & ~wr_1;
    assign rd_2    = en_2 & ~wr_2;
    assign wr_ok_1 = en_1 & wr_1 & ~oor_a1;
    // Port 2 loses a same-address write race, so its data is simply dropped
    assign wr_ok_2 = en_2 & wr_2 & ~oor_a2 & ~(wr_ok_1 & same_a);
    // Write-through only from the opposite port (a port never reads and writes at once)
    assign fwd_1   = FWD & en_2 & wr_2 & ~oor_a2 & same_a;
    assign fwd_2   = FWD & wr_ok_1 & same_a;

    // Raw read word: out-of-range reads as zero, else forwarded or stored data
    always_comb begin
        rdata_1 = mem[idx_1];
        rdata_2 = mem[idx_2];
        if (fwd_1) rdata_1 = data_2;
        if (fwd_2) rdata_2 = data_1;
        if (oor_a1) rdata_1 = '0;
        if (oor_a2) rdata_2 = '0;
    end

    // Storage array; not reset so contents survive rst_n
    always_ff @(posedge clk) begin
        if (wr_ok_1) mem[idx_1] <= data_1;
        if (wr_ok_2) mem[idx_2] <= data_2;
    end

    // Status pulses, registered one cycle after the offending access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll <= 1'b0;
            oor  <= 1'b0;
        end else begin
            coll <= wr_ok_1 & en_2 & wr_2 & ~oor_a2 & same_a;
            oor  <= (en_1 & oor_a1) | (en_2 & oor_a2);
        end
    end

`ifdef DP_RAM_PARITY_EN
    logic par_mem [DEPTH];
    logic rperr_1, rperr_2;

    // Parity bit per word; inj_par_1 lets a bench corrupt a port-1 write
    always_ff @(posedge clk) begin
        if (wr_ok_1) par_mem[idx_1] <= calc_parity(64'(data_1)) ^ inj_par_1;
        if (wr_ok_2) par_mem[idx_2] <= calc_parity(64'(data_2));
    end

    // Recheck on read; forwarded and out-of-range words are never in error
    always_comb begin
        rperr_1 = ~oor_a1 & ~fwd_1 & (calc_parity(64'(mem[idx_1])) != par_mem[idx_1]);
        rperr_2 = ~oor_a2 & ~fwd_2 & (calc_parity(64'(mem[idx_2])) != par_mem[idx_2]);
    end
`endif

    dp_ram_rd_pipe #(.DATA_WIDTH(DATA_WIDTH), .RD_LATENCY(RD_LATENCY)) u_rd_1 (
        .clk(clk), .rst_n(rst_n), .rd_stb(rd_1), .rd_data(rdata_1),
`ifdef DP_RAM_PARITY_EN
        .rd_perr(rperr_1), .perr(perr_1),
`endif
        .out_data(out_1), .out_vld(vld_1)
    );

    dp_ram_rd_pipe #(.DATA_WIDTH(DATA_WIDTH), .RD_LATENCY(RD_LATENCY)) u_rd_2 (
        .clk(clk), .rst_n(rst_n), .rd_stb(rd_2), .rd_data(rdata_2),
`ifdef DP_RAM_PARITY_EN
        .rd_perr(rperr_2), .perr(perr_2),
`endif
        .out_data(out_2), .out_vld(vld_2)
    );

endmodule

// File: tb/tb_dp_ram_pipe.sv
// Scoreboard bench for dp_ram_pipe. Two instances share stimulus:
// u0 = defaults (DEPTH 16, latency 1, old-data), u1 = DEPTH 12, latency 2,
// write-through. Expected responses are hand-computed constants queued with
// the cycle they must appear in; a monitor pops them on every output strobe.
module tb_dp_ram_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en_1 = 0, wr_1 = 0, en_2 = 0, wr_2 = 0;
    logic [3:0] add_1 = 0, add_2 = 0;
    logic [7:0] data_1 = 0, data_2 = 0;
    logic [7:0] o0_1, o0_2, o1_1, o1_2;
    logic       v0_1, v0_2, v1_1, v1_2, c0, c1, r0, r1;
`ifdef DP_RAM_PARITY_EN
    logic       inj_par_1 = 1'b0;
    logic       p0_1, p0_2, p1_1, p1_2;
`endif

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    typedef struct { int idx; int cyc; logic [7:0] data; } ev_t;
    ev_t sb[$];
    string nm[12] = '{"u0_rd1", "u0_rd2", "u1_rd1", "u1_rd2", "u0_coll", "u0_oor",
                      "u1_coll", "u1_oor", "u0_perr1", "u1_perr1", "u0_perr2", "u1_perr2"};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dp_ram_pipe #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16), .RD_LATENCY(1), .RDW_MODE(0)) u0 (
        .clk(clk), .rst_n(rst_n),
        .en_1(en_1), .wr_1(wr_1), .add_1(add_1), .data_1(data_1), .out_1(o0_1), .vld_1(v0_1),
        .en_2(en_2), .wr_2(wr_2), .add_2(add_2), .data_2(data_2), .out_2(o0_2), .vld_2(v0_2),
`ifdef DP_RAM_PARITY_EN
        .inj_par_1(inj_par_1), .perr_1(p0_1), .perr_2(p0_2),
`endif
        .coll(c0), .oor(r0));

    dp_ram_pipe #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(12), .RD_LATENCY(2), .RDW_MODE(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .en_1(en_1), .wr_1(wr_1), .add_1(add_1), .data_1(data_1), .out_1(o1_1), .vld_1(v1_1),
        .en_2(en_2), .wr_2(wr_2), .add_2(add_2), .data_2(data_2), .out_2(o1_2), .vld_2(v1_2),
`ifdef DP_RAM_PARITY_EN
        .inj_par_1(inj_par_1), .perr_1(p1_1), .perr_2(p1_2),
`endif
        .coll(c1), .oor(r1));

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Queue an expected strobe on stream idx, dly edges after the next edge's issue
    task automatic expect_ev(input int idx, input int dly, input logic [7:0] d);
        ev_t e;
        e.idx = idx; e.cyc = cyc + dly; e.data = d;
        sb.push_back(e);
    endtask

    // Apply one cycle of stimulus, return at the following negedge
    task automatic step(input logic e1, input logic w1, input logic [3:0] a1, input logic [7:0] d1,
                        input logic e2, input logic w2, input logic [3:0] a2, input logic [7:0] d2);
        en_1 = e1; wr_1 = w1; add_1 = a1; data_1 = d1;
        en_2 = e2; wr_2 = w2; add_2 = a2; data_2 = d2;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic void take(input int k, input logic fire, input logic [7:0] val);
        int qi[$];
        if (fire !== 1'b1) return;
        n_chk++;
        qi = sb.find_first_index(e) with (e.idx == k);
        if (qi.size() == 0) begin
            n_fail++;
            $display("FAIL %s: unexpected strobe at cycle %0d data %h", nm[k], cyc, val);
            return;
        end
        if (sb[qi[0]].cyc != cyc || sb[qi[0]].data !== val) begin
            n_fail++;
            $display("FAIL %s: got cycle %0d data %h expected cycle %0d data %h",
                     nm[k], cyc, val, sb[qi[0]].cyc, sb[qi[0]].data);
        end
        sb.delete(qi[0]);
    endfunction

    // Monitor: compare every strobe against the scoreboard, flag missed ones
    always @(negedge clk) begin
        int qs[$];
        if (rst_n) begin
            take(0, v0_1, o0_1); take(1, v0_2, o0_2);
            take(2, v1_1, o1_1); take(3, v1_2, o1_2);
            take(4, c0, 8'h00);  take(5, r0, 8'h00);
            take(6, c1, 8'h00);  take(7, r1, 8'h00);
`ifdef DP_RAM_PARITY_EN
            take(8, p0_1, 8'h00);  take(9, p1_1, 8'h00);
            take(10, p0_2, 8'h00); take(11, p1_2, 8'h00);
`endif
            qs = sb.find_first_index(e) with (e.cyc < cyc);
            while (qs.size() > 0) begin
                n_chk++; n_fail++;
                $display("FAIL %s: missing strobe due cycle %0d data %h",
                         nm[sb[qs[0]].idx], sb[qs[0]].cyc, sb[qs[0]].data);
                sb.delete(qs[0]);
                qs = sb.find_first_index(e) with (e.cyc < cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_u0_out1", o0_1, 0); chk("rst_u0_out2", o0_2, 0);
        chk("rst_u0_vld", {6'b0, v0_1, v0_2}, 0); chk("rst_u0_flags", {6'b0, c0, r0}, 0);
        chk("rst_u1_out1", o1_1, 0); chk("rst_u1_out2", o1_2, 0);
        chk("rst_u1_vld", {6'b0, v1_1, v1_2}, 0); chk("rst_u1_flags", {6'b0, c1, r1}, 0);
        rst_n = 1'b1;
        idle(1);

        // Independent writes, then crossed reads
        step(1, 1, 1, 8'hAB, 1, 1, 2, 8'hBC);
        expect_ev(0, 1, 8'hBC); expect_ev(1, 1, 8'hAB);
        expect_ev(2, 2, 8'hBC); expect_ev(3, 2, 8'hAB);
        step(1, 0, 2, 0, 1, 0, 1, 0);

        // Write/write collision: port 1 wins
        expect_ev(4, 1, 0); expect_ev(6, 1, 0);
        step(1, 1, 3, 8'h11, 1, 1, 3, 8'h22);
        chk("hold_u0_out1", o0_1, 8'hBC);
        chk("hold_u0_out2", o0_2, 8'hAB);
        expect_ev(0, 1, 8'h11); expect_ev(2, 2, 8'h11);
        step(1, 0, 3, 0, 0, 0, 0, 0);

        // Cross-port read during write: u0 old data, u1 new data
        step(1, 1, 4, 8'h55, 0, 0, 0, 0);
        expect_ev(1, 1, 8'h55); expect_ev(3, 2, 8'hDE);
        step(1, 1, 4, 8'hDE, 1, 0, 4, 0);
        expect_ev(1, 1, 8'hDE); expect_ev(3, 2, 8'hDE);
        step(0, 0, 0, 0, 1, 0, 4, 0);

        // Back-to-back reads; port 2 also reads the same address in the first
        expect_ev(0, 1, 8'hAB); expect_ev(2, 2, 8'hAB);
        expect_ev(1, 1, 8'hAB); expect_ev(3, 2, 8'hAB);
        step(1, 0, 1, 0, 1, 0, 1, 0);
        expect_ev(0, 1, 8'hBC); expect_ev(2, 2, 8'hBC);
        step(1, 0, 2, 0, 0, 0, 0, 0);
        expect_ev(0, 1, 8'h11); expect_ev(2, 2, 8'h11);
        step(1, 0, 3, 0, 0, 0, 0, 0);

        // Addresses 13/15: legal in u0, out of range in u1
        expect_ev(7, 1, 0);
        step(1, 1, 13, 8'hFF, 1, 1, 15, 8'h77);
        expect_ev(7, 1, 0);
        expect_ev(0, 1, 8'hFF); expect_ev(1, 1, 8'h77);
        expect_ev(2, 2, 8'h00); expect_ev(3, 2, 8'h00);
        step(1, 0, 13, 0, 1, 0, 15, 0);
        expect_ev(0, 1, 8'hAB); expect_ev(1, 1, 8'hDE);
        expect_ev(2, 2, 8'hAB); expect_ev(3, 2, 8'hDE);
        step(1, 0, 1, 0, 1, 0, 4, 0);
        idle(3);

        // Reset between the two latency edges of a u1 read
        expect_ev(0, 1, 8'hAB);
        step(1, 0, 1, 0, 0, 0, 0, 0);
        en_1 = 0;
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_u1_out1", o1_1, 0); chk("mid_rst_u1_vld", {7'b0, v1_1}, 0);
        chk("mid_rst_u0_out1", o0_1, 0); chk("mid_rst_u0_vld", {7'b0, v0_1}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(4);
        expect_ev(0, 1, 8'hAB); expect_ev(2, 2, 8'hAB);
        step(1, 0, 1, 0, 0, 0, 0, 0);
        idle(3);

`ifdef DP_RAM_PARITY_EN
        // Corrupted parity on a port-1 write is reported on read
        inj_par_1 = 1'b1;
        step(1, 1, 5, 8'h5A, 0, 0, 0, 0);
        inj_par_1 = 1'b0;
        expect_ev(0, 1, 8'h5A); expect_ev(2, 2, 8'h5A);
        expect_ev(8, 1, 0);     expect_ev(9, 2, 0);
        step(1, 0, 5, 0, 0, 0, 0, 0);
        idle(3);
`endif

        while (sb.size() > 0) begin
            n_chk++; n_fail++;
            $display("FAIL %s: never seen, due cycle %0d data %h",
                     nm[sb[0].idx], sb[0].cyc, sb[0].data);
            void'(sb.pop_front());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
